clause_array: RTL and testbench

- Storage and combinational BCP (unit propagation) engine for one SAT "bin".
- Holds NUM_CLAUSES clause rows over NUM_VARS local variables; each row stores 2-bit literals plus a length.
- Given current variable values/levels, it combinationally produces implied assignments, their decision levels and a conflict flag.
- Reports the first free row, where the next learnt clause is inserted.

---
 rtl/clause_array_pkg.sv | 20 ++
 rtl/clause_array_row.sv | 78 +++++++
 rtl/clause_array.sv | 130 +++++++++++++
 tb/tb_clause_array.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clause_array_pkg.sv
// Shared literal/value encodings for the clause array and its rows.
package clause_array_pkg;

    localparam int unsigned LIT_W = 2;
    localparam int unsigned VAL_W = 3;

    localparam logic [LIT_W-1:0] LIT_NONE = 2'd0;
    localparam logic [LIT_W-1:0] LIT_POS  = 2'd1;
    localparam logic [LIT_W-1:0] LIT_NEG  = 2'd2;

    localparam logic [LIT_W-1:0] VAL_FREE  = 2'd0;
    localparam logic [LIT_W-1:0] VAL_TRUE  = 2'd1;
    localparam logic [LIT_W-1:0] VAL_FALSE = 2'd2;

    // The illegal code 11 is treated like an absent literal.
    function automatic logic lit_present(input logic [LIT_W-1:0] lit);
        return (lit == LIT_POS) || (lit == LIT_NEG);
    endfunction

endpackage

// File: rtl/clause_array_row.sv
// One clause row: literal/length storage plus combinational unit/conflict detection.
module clause_row
    import clause_array_pkg::*;
#(
    parameter int unsigned NUM_VARS    = 8,
    parameter int unsigned WIDTH_LVL   = 16,
    parameter int unsigned WIDTH_C_LEN = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr,
    input  logic [NUM_VARS*LIT_W-1:0]     clause_in,
    input  logic [WIDTH_C_LEN:0]          len_in,
    output logic [NUM_VARS*LIT_W-1:0]     lits,
    output logic [WIDTH_C_LEN:0]          len,
    input  logic [NUM_VARS*LIT_W-1:0]     var_state,
    input  logic [NUM_VARS*WIDTH_LVL-1:0] var_lvl,
    output logic [NUM_VARS-1:0]           imply_pos,
    output logic [NUM_VARS-1:0]           imply_neg,
    output logic [WIDTH_LVL-1:0]          imply_lvl,
    output logic                          conflict
);

    logic [NUM_VARS*LIT_W-1:0] lits_q;
    logic [WIDTH_C_LEN:0]      len_q;
    logic                      any_true, any_present, free_seen, multi_free, unit;
    logic [NUM_VARS-1:0]       free_mask, pos_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lits_q <= '0;
            len_q  <= '0;
        end else if (wr) begin
            lits_q <= clause_in;
            len_q  <= len_in;
        end
    end

    assign lits = lits_q;
    assign len  = len_q;

    // The implied level is the latest level among the literals already falsified.
    always_comb begin
        logic [LIT_W-1:0] lit, st;
        lit         = LIT_NONE;
        st          = VAL_FREE;
        any_true    = 1'b0;
        any_present = 1'b0;
        free_seen   = 1'b0;
        multi_free  = 1'b0;
        free_mask   = '0;
        pos_mask    = '0;
        imply_lvl   = '0;
        for (int k = 0; k < NUM_VARS; k++) begin
            lit = lits_q[k*LIT_W +: LIT_W];
            st  = var_state[k*LIT_W +: LIT_W];
            pos_mask[k] = (lit == LIT_POS);
            if (lit_present(lit)) begin
                any_present = 1'b1;
                if (st == VAL_FREE) begin
                    multi_free   = multi_free | free_seen;
                    free_seen    = 1'b1;
                    free_mask[k] = 1'b1;
                end else if (st == lit) begin
                    any_true = 1'b1;
                end else if (var_lvl[k*WIDTH_LVL +: WIDTH_LVL] > imply_lvl) begin
                    imply_lvl = var_lvl[k*WIDTH_LVL +: WIDTH_LVL];
                end
            end
        end
    end

    assign unit      = !any_true && free_seen && !multi_free;
    assign conflict  = !any_true && !free_seen && any_present;
    assign imply_pos = unit ? (free_mask & pos_mask) : '0;
    assign imply_neg = unit ? (free_mask & ~pos_mask) : '0;

endmodule

// File: rtl/clause_array.sv
// Clause storage and combinational unit-propagation engine for one SAT bin.
module clause_array
    import clause_array_pkg::*;
#(
    parameter int unsigned NUM_CLAUSES = 8,
    parameter int unsigned NUM_VARS    = 8,
    parameter int unsigned WIDTH_LVL   = 16,
    parameter int unsigned WIDTH_C_LEN = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLAUSES-1:0]        wr_i,
    input  logic [NUM_VARS*LIT_W-1:0]     clause_i,
    input  logic [WIDTH_C_LEN:0]          clause_len_i,
    input  logic [NUM_CLAUSES-1:0]        rd_i,
    output logic [NUM_VARS*LIT_W-1:0]     clause_o,
    output logic [WIDTH_C_LEN:0]          clause_len_o,
    input  logic [NUM_VARS*VAL_W-1:0]     var_value_i,
    output logic [NUM_VARS*VAL_W-1:0]     var_value_o,
    input  logic [NUM_VARS*WIDTH_LVL-1:0] var_lvl_i,
    output logic [NUM_VARS*WIDTH_LVL-1:0] var_lvl_o,
    input  logic                          apply_imply_i,
    input  logic                          apply_bkt_i,
    output logic [NUM_CLAUSES-1:0]        learntc_insert_index_o,
    output logic                          conflict_o
);

    logic [NUM_VARS*LIT_W-1:0] row_lits [NUM_CLAUSES];
    logic [WIDTH_C_LEN:0]      row_len  [NUM_CLAUSES];
    logic [NUM_VARS-1:0]       row_pos  [NUM_CLAUSES];
    logic [NUM_VARS-1:0]       row_neg  [NUM_CLAUSES];
    logic [WIDTH_LVL-1:0]      row_lvl  [NUM_CLAUSES];
    logic [NUM_CLAUSES-1:0]    row_conflict;
    logic [NUM_CLAUSES-1:0]    learntc_insert_index;
    logic [NUM_VARS*LIT_W-1:0] var_state;
    logic                      opposite;

    always_comb begin
        var_state = '0;
        for (int k = 0; k < NUM_VARS; k++) begin
            var_state[k*LIT_W +: LIT_W] = var_value_i[k*VAL_W +: LIT_W];
        end
    end

    for (genvar r = 0; r < NUM_CLAUSES; r++) begin : g_row
        clause_row #(
            .NUM_VARS    (NUM_VARS),
            .WIDTH_LVL   (WIDTH_LVL),
            .WIDTH_C_LEN (WIDTH_C_LEN)
        ) u_row (
            .clk       (clk),
            .rst       (rst),
            .wr        (wr_i[r]),
            .clause_in (clause_i),
            .len_in    (clause_len_i),
            .lits      (row_lits[r]),
            .len       (row_len[r]),
            .var_state (var_state),
            .var_lvl   (var_lvl_i),
            .imply_pos (row_pos[r]),
            .imply_neg (row_neg[r]),
            .imply_lvl (row_lvl[r]),
            .conflict  (row_conflict[r])
        );
    end

    // Lowest-index implying row wins; any opposite pair still flags a conflict.
    always_comb begin
        logic                 any_pos, any_neg, found, pick_neg;
        logic [WIDTH_LVL-1:0] pick_lvl;
        var_value_o = var_value_i;
        var_lvl_o   = var_lvl_i;
        opposite    = 1'b0;
        any_pos     = 1'b0;
        any_neg     = 1'b0;
        found       = 1'b0;
        pick_neg    = 1'b0;
        pick_lvl    = '0;
        for (int k = 0; k < NUM_VARS; k++) begin
            any_pos  = 1'b0;
            any_neg  = 1'b0;
            found    = 1'b0;
            pick_neg = 1'b0;
            pick_lvl = '0;
            for (int r = 0; r < NUM_CLAUSES; r++) begin
                any_pos = any_pos | row_pos[r][k];
                any_neg = any_neg | row_neg[r][k];
                if (!found && (row_pos[r][k] || row_neg[r][k])) begin
                    found    = 1'b1;
                    pick_neg = row_neg[r][k];
                    pick_lvl = row_lvl[r];
                end
            end
            opposite = opposite | (any_pos & any_neg);
            if (apply_imply_i && !apply_bkt_i && found &&
                var_state[k*LIT_W +: LIT_W] == VAL_FREE) begin
                var_value_o[k*VAL_W +: VAL_W]     = {1'b1, pick_neg ? VAL_FALSE : VAL_TRUE};
                var_lvl_o[k*WIDTH_LVL +: WIDTH_LVL] = pick_lvl;
            end
        end
    end

    assign conflict_o = !apply_bkt_i && ((|row_conflict) || opposite);

    always_comb begin
        logic found;
        found                = 1'b0;
        learntc_insert_index = '0;
        for (int r = 0; r < NUM_CLAUSES; r++) begin
            if (!found && row_len[r] == '0) begin
                learntc_insert_index[r] = 1'b1;
                found                   = 1'b1;
            end
        end
    end

    assign learntc_insert_index_o = learntc_insert_index;

    always_comb begin
        clause_o     = {NUM_VARS{LIT_NONE}};
        clause_len_o = '0;
        for (int r = 0; r < NUM_CLAUSES; r++) begin
            if (rd_i[r]) begin
                clause_o     = clause_o | row_lits[r];
                clause_len_o = clause_len_o | row_len[r];
            end
        end
    end

endmodule

// File: tb/tb_clause_array.sv
// Scoreboard bench for clause_array: driver pushes model expectations, monitor compares.
module tb_clause_array;

    typedef struct packed {
        logic [23:0]  val;
        logic [127:0] lvl;
        logic         conf;
        logic [7:0]   ins;
        logic [15:0]  cl;
        logic [4:0]   clen;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   wr_i, rd_i, learntc_insert_index_o;
    logic [15:0]  clause_i, clause_o;
    logic [4:0]   clause_len_i, clause_len_o;
    logic [23:0]  var_value_i, var_value_o;
    logic [127:0] var_lvl_i, var_lvl_o;
    logic         apply_imply_i, apply_bkt_i, conflict_o;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  cur;
    string cur_nm;
    int    mem_lit[8][8];
    int    mem_len[8];
    int    checks = 0;
    int    errors = 0;
    logic  obs_valid = 1'b0;

    clause_array dut (
        .clk                    (clk),
        .rst                    (rst),
        .wr_i                   (wr_i),
        .clause_i               (clause_i),
        .clause_len_i           (clause_len_i),
        .rd_i                   (rd_i),
        .clause_o               (clause_o),
        .clause_len_o           (clause_len_o),
        .var_value_i            (var_value_i),
        .var_value_o            (var_value_o),
        .var_lvl_i              (var_lvl_i),
        .var_lvl_o              (var_lvl_o),
        .apply_imply_i          (apply_imply_i),
        .apply_bkt_i            (apply_bkt_i),
        .learntc_insert_index_o (learntc_insert_index_o),
        .conflict_o             (conflict_o)
    );

    always #5 clk = ~clk;

    // Reference: classify each row from its literal counts, then resolve per variable.
    function automatic exp_t model();
        exp_t e;
        int   imp_row[8];
        int   imp_lit[8];
        int   imp_lvl[8];
        bit   seen_pos[8];
        bit   seen_neg[8];
        bit   conf;
        e.val = var_value_i;
        e.lvl = var_lvl_i;
        conf  = 1'b0;
        for (int v = 0; v < 8; v++) begin
            imp_row[v] = -1; imp_lit[v] = 0; imp_lvl[v] = 0;
            seen_pos[v] = 1'b0; seen_neg[v] = 1'b0;
        end
        for (int r = 0; r < 8; r++) begin
            int nfree, ntrue, npres, fvar, flvl;
            nfree = 0; ntrue = 0; npres = 0; fvar = 0; flvl = 0;
            for (int v = 0; v < 8; v++) begin
                int lit, st;
                lit = mem_lit[r][v];
                st  = int'(var_value_i[v*3 +: 2]);
                if (lit == 1 || lit == 2) begin
                    npres++;
                    if (st == 0) begin
                        nfree++;
                        fvar = v;
                    end else if (st == lit) begin
                        ntrue++;
                    end else if (int'(var_lvl_i[v*16 +: 16]) > flvl) begin
                        flvl = int'(var_lvl_i[v*16 +: 16]);
                    end
                end
            end
            if (ntrue == 0 && npres > 0 && nfree == 0) conf = 1'b1;
            if (ntrue == 0 && nfree == 1) begin
                if (mem_lit[r][fvar] == 1) seen_pos[fvar] = 1'b1;
                else seen_neg[fvar] = 1'b1;
                if (imp_row[fvar] < 0) begin
                    imp_row[fvar] = r;
                    imp_lit[fvar] = mem_lit[r][fvar];
                    imp_lvl[fvar] = flvl;
                end
            end
        end
        for (int v = 0; v < 8; v++) begin
            if (seen_pos[v] && seen_neg[v]) conf = 1'b1;
            if (apply_imply_i && !apply_bkt_i && imp_row[v] >= 0 &&
                var_value_i[v*3 +: 2] == 2'b00) begin
                e.val[v*3 +: 3]   = {1'b1, 2'(imp_lit[v])};
                e.lvl[v*16 +: 16] = 16'(imp_lvl[v]);
            end
        end
        e.conf = conf && !apply_bkt_i;
        e.ins  = '0;
        for (int r = 7; r >= 0; r--) if (mem_len[r] == 0) e.ins = 8'd1 << r;
        e.cl   = '0;
        e.clen = '0;
        for (int r = 0; r < 8; r++) begin
            if (rd_i[r]) begin
                for (int v = 0; v < 8; v++) e.cl[v*2 +: 2] = e.cl[v*2 +: 2] | 2'(mem_lit[r][v]);
                e.clen = e.clen | 5'(mem_len[r]);
            end
        end
        return e;
    endfunction

    task automatic cmp(input string nm, input string fld, input logic [127:0] act,
                       input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s got=%0h want=%0h", nm, fld, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (obs_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty got=sample want=queued_expectation");
            end else begin
                cur    = exp_q.pop_front();
                cur_nm = name_q.pop_front();
                cmp(cur_nm, "var_value", 128'(var_value_o), 128'(cur.val));
                cmp(cur_nm, "var_lvl", var_lvl_o, cur.lvl);
                cmp(cur_nm, "conflict", 128'(conflict_o), 128'(cur.conf));
                cmp(cur_nm, "insert_index", 128'(learntc_insert_index_o), 128'(cur.ins));
                cmp(cur_nm, "clause", 128'(clause_o), 128'(cur.cl));
                cmp(cur_nm, "clause_len", 128'(clause_len_o), 128'(cur.clen));
            end
        end
    end

    task automatic do_check(input string nm);
        exp_q.push_back(model());
        name_q.push_back(nm);
        obs_valid = 1'b1;
        @(negedge clk);
        #1;
        obs_valid = 1'b0;
    endtask

    task automatic write_rows(input logic [7:0] mask, input logic [15:0] lits,
                              input logic [4:0] len);
        wr_i = mask; clause_i = lits; clause_len_i = len;
        @(posedge clk);
        #1;
        wr_i = '0;
        for (int r = 0; r < 8; r++) begin
            if (mask[r]) begin
                for (int v = 0; v < 8; v++) mem_lit[r][v] = int'(lits[v*2 +: 2]);
                mem_len[r] = int'(len);
            end
        end
    endtask

    // h holds one nibble per variable, var0 in the most significant nibble.
    task automatic write_clause(input int r, input logic [31:0] h);
        logic [15:0] l;
        int          n;
        n = 0;
        for (int v = 0; v < 8; v++) begin
            l[v*2 +: 2] = h[(7-v)*4 +: 2];
            if (h[(7-v)*4 +: 2] == 2'd1 || h[(7-v)*4 +: 2] == 2'd2) n++;
        end
        write_rows(8'd1 << r, l, 5'(n));
    endtask

    task automatic set_values(input logic [31:0] h);
        for (int v = 0; v < 8; v++) var_value_i[v*3 +: 3] = h[(7-v)*4 +: 3];
    endtask

    task automatic clear_model();
        for (int r = 0; r < 8; r++) begin
            mem_len[r] = 0;
            for (int v = 0; v < 8; v++) mem_lit[r][v] = 0;
        end
    endtask

    task automatic load_base();
        write_clause(0, 32'h2010_0000);
        write_clause(1, 32'h0201_0200);
        write_clause(2, 32'h2001_2000);
        write_clause(3, 32'h1100_1000);
        write_clause(4, 32'h0120_2000);
    endtask

    initial begin
        rst = 1'b0; wr_i = '0; rd_i = '0; clause_i = '0; clause_len_i = '0;
        var_value_i = '0; var_lvl_i = '0; apply_imply_i = 1'b0; apply_bkt_i = 1'b0;
        clear_model();
        do_check("reset");
        cmp("reset_insert", "insert_index", 128'(learntc_insert_index_o), 128'(8'b0000_0001));
        rst = 1'b1;

        load_base();
        do_check("rows0_4");
        cmp("rows0_4_insert", "insert_index", 128'(learntc_insert_index_o), 128'(8'b0010_0000));
        write_clause(5, 32'h0001_0020);
        write_clause(6, 32'h2001_0101);
        write_clause(7, 32'h1010_0120);
        do_check("full");
        for (int r = 0; r < 8; r++) begin
            rd_i = 8'd1 << r;
            do_check($sformatf("read_row%0d", r));
        end
        rd_i = '0;

        rst = 1'b0;
        #1;
        clear_model();
        rst = 1'b1;
        load_base();
        for (int v = 0; v < 8; v++) var_lvl_i[v*16 +: 16] = 16'(v + 1);
        apply_imply_i = 1'b1;
        set_values(32'h0200_0200);
        do_check("no_unit");
        set_values(32'h1100_0000);
        do_check("unit_var2");
        cmp("unit_var2_val", "var2", 128'(var_value_o[8:6]), 128'(3'b101));
        cmp("unit_var2_lvl", "var2_lvl", 128'(var_lvl_o[47:32]), 128'(16'd1));
        apply_imply_i = 1'b0;
        do_check("imply_off");
        apply_imply_i = 1'b1;
        apply_bkt_i   = 1'b1;
        do_check("backtrack");
        apply_bkt_i = 1'b0;
        set_values(32'h1020_0000);
        do_check("row0_conflict");
        cmp("row0_conflict_c", "conflict", 128'(conflict_o), 128'(1'b1));
        rst = 1'b0;
        #1;
        clear_model();
        do_check("mid_reset");
        cmp("mid_reset_c", "conflict", 128'(conflict_o), 128'(1'b0));
        rst = 1'b1;

        load_base();
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                logic [15:0] l;
                int          n, lit;
                n = 0;
                for (int v = 0; v < 8; v++) begin
                    lit = $urandom_range(0, 5);
                    if (lit > 3) lit = 0;
                    l[v*2 +: 2] = 2'(lit);
                    if (lit == 1 || lit == 2) n++;
                end
                if ($urandom_range(0, 7) == 0) n = $urandom_range(0, 31);
                write_rows(8'($urandom), l, 5'(n));
            end
            for (int v = 0; v < 8; v++) begin
                int st;
                st = $urandom_range(0, 6);
                if (st > 3) st = 0;
                var_value_i[v*3 +: 3] = {1'($urandom), 2'(st)};
                var_lvl_i[v*16 +: 16] = 16'($urandom);
            end
            apply_imply_i = ($urandom_range(0, 3) != 0);
            apply_bkt_i   = ($urandom_range(0, 5) == 0);
            rd_i = ($urandom_range(0, 3) == 0) ? 8'd0 : (8'd1 << $urandom_range(0, 7));
            do_check("random");
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
